l2_tlb_tag_lookup: RTL and testbench

Tag/valid stage of the 4-way L2 TLB, directly upstream of the L2 TLB item-generate stage. It accepts a VPN lookup, compares it against the four tag ways of the indexed set, and produces the 5-bit hit vector plus set index that the item-generate stage consumes: bits 3:0 are ways 0–3, bit 4 is passthrough. On a miss it owns the page-table-walker (PTW) request/response handshake, picks a victim way, installs the tag, and pulses a refill strobe so the external PPN/permission arrays are written.

---
 rtl/l2_tlb_tag_lookup.sv | 177 +++++++++++++++++
 tb/tb_l2_tlb_tag_lookup.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tlb_tag_lookup.sv
// l2_tlb_tag_lookup: tag/valid stage of the 4-way L2 TLB.
// Compares a lookup VPN against the four tag ways of the indexed set and
// returns a one-hot-or-zero hit vector (bit 4 = passthrough). On a miss it
// runs the PTW request/response handshake, picks a victim way, installs the
// tag and pulses refill_valid so the external PPN/permission arrays follow.
//
// Handshake rule for req_* and ptw_req_*: a transfer happens on a rising
// edge where valid && ready are both high; valid is never withdrawn and its
// payload never changes until that transfer happens.
`timescale 1ns/1ps
module l2_tlb_tag_lookup #(
    parameter  int SETS  = 16,
    parameter  int VPN_W = 31,
    localparam int IW    = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VPN_W-1:0] req_vpn,
    input  logic             req_passthrough,
    input  logic             flush,
    output logic             resp_valid,
    output logic [4:0]       resp_hitsVec,
    output logic             resp_miss,
    output logic [IW-1:0]    resp_idx,
    output logic [3:0]       resp_valid_way,
    output logic             ptw_req_valid,
    input  logic             ptw_req_ready,
    output logic [VPN_W-1:0] ptw_req_vpn,
    input  logic             ptw_resp_valid,
    input  logic             ptw_resp_error,
    output logic             refill_valid,
    output logic [1:0]       refill_way,
    output logic [IW-1:0]    refill_idx,
    output logic [1:0]       dbg_state
);

    localparam int TW = VPN_W - IW;

    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_RESP     = 2'd1,
        S_PTW_REQ  = 2'd2,
        S_PTW_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       valid_q [SETS];
    logic [TW-1:0]    tag_q   [4][SETS];
    logic [1:0]       rr_q;
    logic             drop_q;
    logic [VPN_W-1:0] cap_vpn_q;
    logic [1:0]       refill_way_q;
    logic [IW-1:0]    refill_idx_q;

    logic [IW-1:0]    req_idx, cap_idx;
    logic [TW-1:0]    req_tag, cap_tag;
    logic [4:0]       lookup_hits;
    logic [3:0]       set_valid;
    logic [1:0]       victim_way;
    logic             accept;

    assign req_idx   = req_vpn[IW-1:0];
    assign req_tag   = req_vpn[VPN_W-1:IW];
    assign cap_idx   = cap_vpn_q[IW-1:0];
    assign cap_tag   = cap_vpn_q[VPN_W-1:IW];
    assign accept    = req_valid && req_ready;
    assign dbg_state = state_q;

    // Tag compare against the set addressed by the incoming request; the
    // result is registered at accept and presented during S_RESP. Arrays can
    // only change from a flush at the end of S_RESP, so this equals the
    // compare against the captured VPN in the response cycle.
    always_comb begin
        lookup_hits = '0;
        for (int w = 0; w < 4; w++) begin
            lookup_hits[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
        end
        if (req_passthrough) lookup_hits = 5'b10000;
    end

    // Victim: lowest-index invalid way, else the round-robin way.
    always_comb begin
        set_valid  = valid_q[cap_idx];
        victim_way = rr_q;
        for (int w = 3; w >= 0; w--) begin
            if (!set_valid[w]) victim_way = 2'(w);
        end
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        ptw_req_valid = 1'b0;
        refill_valid  = 1'b0;
        case (state_q)
            S_READY: begin
                req_ready = !flush;
                if (req_valid && !flush) state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = (resp_hitsVec == 5'd0) ? S_PTW_REQ : S_READY;
            end
            S_PTW_REQ: begin
                ptw_req_valid = 1'b1;
                if (ptw_req_ready) state_d = S_PTW_WAIT;
            end
            S_PTW_WAIT: begin
                if (ptw_resp_valid) begin
                    state_d      = S_READY;
                    refill_valid = !ptw_resp_error && !drop_q && !flush;
                end
            end
            default: state_d = S_READY;
        endcase
    end

    assign resp_miss  = resp_valid && (resp_hitsVec == 5'd0);
    assign refill_way = refill_valid ? victim_way : refill_way_q;
    assign refill_idx = refill_valid ? cap_idx    : refill_idx_q;

    // State register, captured request, held response/refill fields, rr, drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_READY;
            rr_q           <= 2'd0;
            drop_q         <= 1'b0;
            cap_vpn_q      <= '0;
            resp_hitsVec   <= '0;
            resp_idx       <= '0;
            resp_valid_way <= '0;
            ptw_req_vpn    <= '0;
            refill_way_q   <= '0;
            refill_idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_vpn_q      <= req_vpn;
                resp_hitsVec   <= lookup_hits;
                resp_idx       <= req_idx;
                resp_valid_way <= valid_q[req_idx];
            end
            if (resp_miss) ptw_req_vpn <= cap_vpn_q;
            if (state_q == S_PTW_WAIT && ptw_resp_valid) begin
                drop_q <= 1'b0;
            end else if (flush && (state_q == S_PTW_REQ || state_q == S_PTW_WAIT)) begin
                drop_q <= 1'b1;
            end
            if (refill_valid) begin
                refill_way_q <= victim_way;
                refill_idx_q <= cap_idx;
                if (&set_valid) rr_q <= rr_q + 2'd1;
            end
        end
    end

    // Valid bits: flush wins over a fill in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (refill_valid) begin
            valid_q[cap_idx][victim_way] <= 1'b1;
        end
    end

    // Tag array write on refill; tags carry no reset.
    always_ff @(posedge clk) begin
        if (refill_valid) tag_q[victim_way][cap_idx] <= cap_tag;
    end

endmodule

// File: tb/tb_l2_tlb_tag_lookup.sv
// Bench for l2_tlb_tag_lookup: directed steps followed by random lookups,
// checked against a set/way table model of the TLB tags.
`timescale 1ns/1ps
`define CHK(t, o, e) check(t, 64'(o), 64'(e))
module tb_l2_tlb_tag_lookup;

    localparam int SETS  = 16;
    localparam int VPN_W = 31;
    localparam int IW    = 4;
    localparam int TW    = VPN_W - IW;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [VPN_W-1:0] req_vpn = '0;
    logic             req_passthrough = 1'b0;
    logic             flush = 1'b0;
    logic             resp_valid;
    logic [4:0]       resp_hitsVec;
    logic             resp_miss;
    logic [IW-1:0]    resp_idx;
    logic [3:0]       resp_valid_way;
    logic             ptw_req_valid;
    logic             ptw_req_ready = 1'b0;
    logic [VPN_W-1:0] ptw_req_vpn;
    logic             ptw_resp_valid = 1'b0;
    logic             ptw_resp_error = 1'b0;
    logic             refill_valid;
    logic [1:0]       refill_way;
    logic [IW-1:0]    refill_idx;
    logic [1:0]       dbg_state;

    l2_tlb_tag_lookup #(.SETS(SETS), .VPN_W(VPN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
        .req_passthrough(req_passthrough), .flush(flush),
        .resp_valid(resp_valid), .resp_hitsVec(resp_hitsVec), .resp_miss(resp_miss),
        .resp_idx(resp_idx), .resp_valid_way(resp_valid_way),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_req_vpn(ptw_req_vpn), .ptw_resp_valid(ptw_resp_valid),
        .ptw_resp_error(ptw_resp_error), .refill_valid(refill_valid),
        .refill_way(refill_way), .refill_idx(refill_idx), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which (way,set) slots hold which tag, plus rr.
    bit            mv [4][SETS];
    logic [TW-1:0] mt [4][SETS];
    int            mrr;

    // Scoreboard: expected hit vectors, one per issued lookup.
    logic [4:0] exp_q[$];
    logic [4:0] exp_h;

    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_unexpected_resp hits=0x%0h", resp_hitsVec);
            end else begin
                exp_h = exp_q.pop_front();
                n_checks++;
                if (resp_hitsVec !== exp_h) begin
                    n_fail++;
                    $error("FAIL sb_hits observed=0x%0h expected=0x%0h", resp_hitsVec, exp_h);
                end
                n_checks++;
                if (resp_miss !== (exp_h == 5'd0)) begin
                    n_fail++;
                    $error("FAIL sb_miss observed=%0b expected=%0b", resp_miss, (exp_h == 5'd0));
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < SETS; s++) mv[w][s] = 1'b0;
    endtask

    // Issue one lookup and check the response; leaves time at negedge+1 of t+2.
    task automatic lookup(input logic [VPN_W-1:0] vpn, input bit pt, output bit miss);
        int         idx;
        logic [TW-1:0] tg;
        logic [4:0] eh;
        logic [3:0] ew;
        idx = int'(vpn[IW-1:0]);
        tg  = vpn[VPN_W-1:IW];
        eh  = '0;
        ew  = '0;
        for (int w = 0; w < 4; w++) begin
            ew[w] = mv[w][idx];
            if (mv[w][idx] && mt[w][idx] == tg) eh[w] = 1'b1;
        end
        if (pt) eh = 5'b10000;
        miss = (eh == 5'd0);
        exp_q.push_back(eh);
        @(negedge clk);
        req_valid = 1'b1; req_vpn = vpn; req_passthrough = pt;
        #1;
        `CHK("req_ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_passthrough = 1'b0;
        #1;
        `CHK("resp_valid", resp_valid, 1);
        `CHK("resp_hitsVec", resp_hitsVec, eh);
        `CHK("resp_miss", resp_miss, miss);
        `CHK("resp_idx", resp_idx, idx);
        `CHK("resp_valid_way", resp_valid_way, ew);
        `CHK("hits_onehot0", $onehot0(resp_hitsVec), 1);
        `CHK("req_ready_in_resp", req_ready, 0);
        @(negedge clk);
        #1;
        `CHK("resp_valid_drop", resp_valid, 0);
        if (miss) begin
            `CHK("ptw_req_valid", ptw_req_valid, 1);
            `CHK("ptw_req_vpn", ptw_req_vpn, vpn);
            `CHK("req_ready_ptw", req_ready, 0);
        end else begin
            `CHK("req_ready_after_hit", req_ready, 1);
            `CHK("no_ptw_on_hit", ptw_req_valid, 0);
        end
    endtask

    // Serve the walk for a lookup that missed; starts in the PTW request state.
    task automatic serve(input logic [VPN_W-1:0] vpn, input int hold, input bit err,
                         input bit flush_wait, input int lat);
        int  idx;
        int  vw;
        bit  all_v;
        bit  exp_fill;
        bit  dropped;
        dropped = 1'b0;
        idx = int'(vpn[IW-1:0]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            `CHK("ptw_hold_valid", ptw_req_valid, 1);
            `CHK("ptw_hold_vpn", ptw_req_vpn, vpn);
        end
        ptw_req_ready = 1'b1;
        @(posedge clk);
        #1 ptw_req_ready = 1'b0;
        @(negedge clk);
        #1;
        `CHK("ptw_req_dropped", ptw_req_valid, 0);
        `CHK("refill_idle", refill_valid, 0);
        if (flush_wait) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            model_clear();
            dropped = 1'b1;
        end
        repeat (lat) @(negedge clk);
        @(negedge clk);
        vw = mrr;
        all_v = 1'b1;
        for (int w = 3; w >= 0; w--) if (!mv[w][idx]) begin vw = w; all_v = 1'b0; end
        exp_fill = !err && !dropped;
        ptw_resp_valid = 1'b1; ptw_resp_error = err;
        #1;
        `CHK("refill_valid", refill_valid, exp_fill);
        if (exp_fill) begin
            `CHK("refill_way", refill_way, vw);
            `CHK("refill_idx", refill_idx, idx);
        end
        @(posedge clk);
        #1 ptw_resp_valid = 1'b0; ptw_resp_error = 1'b0;
        if (exp_fill) begin
            mv[vw][idx] = 1'b1;
            mt[vw][idx] = vpn[VPN_W-1:IW];
            if (all_v) mrr = (mrr + 1) % 4;
        end
        @(negedge clk);
        #1;
        `CHK("req_ready_after_walk", req_ready, 1);
        `CHK("refill_pulse_end", refill_valid, 0);
        if (exp_fill) `CHK("refill_way_held", refill_way, vw);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit miss;
        logic [VPN_W-1:0] v;
        model_clear();
        mrr = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        `CHK("rst_req_ready", req_ready, 1);
        `CHK("rst_resp_valid", resp_valid, 0);
        `CHK("rst_hits", resp_hitsVec, 0);
        `CHK("rst_ptw_req_valid", ptw_req_valid, 0);
        `CHK("rst_refill_valid", refill_valid, 0);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        `CHK("post_rst_req_ready", req_ready, 1);

        // Cold miss, fill, then hit
        lookup(31'h12345, 1'b0, miss);
        `CHK("first_lookup_miss", miss, 1);
        serve(31'h12345, 0, 1'b0, 1'b0, 1);
        `CHK("first_fill_way", refill_way, 0);
        `CHK("first_fill_idx", refill_idx, 5);
        lookup(31'h12345, 1'b0, miss);
        `CHK("first_relookup_hit", miss, 0);

        // Fill set 3, then two evictions via rr
        for (int t = 1; t <= 6; t++) begin
            v = VPN_W'((t << IW) | 3);
            lookup(v, 1'b0, miss);
            if (miss) serve(v, 0, 1'b0, 1'b0, 0);
            if (t == 5) `CHK("evict1_way", refill_way, 0);
            if (t == 6) `CHK("evict2_way", refill_way, 1);
        end

        // Passthrough
        lookup(31'h7777, 1'b1, miss);
        `CHK("pt_no_miss", miss, 0);

        // Walk error: nothing installed
        lookup(31'h55558, 1'b0, miss);
        serve(31'h55558, 1, 1'b1, 1'b0, 2);
        lookup(31'h55558, 1'b0, miss);
        `CHK("err_relookup_miss", miss, 1);
        // Stalled PTW request, then flush during the wait
        serve(31'h55558, 5, 1'b0, 1'b1, 1);
        lookup(31'h55558, 1'b0, miss);
        `CHK("flush_relookup_miss", miss, 1);
        serve(31'h55558, 0, 1'b0, 1'b0, 0);

        // Reset mid-walk
        lookup(31'h0ABC1, 1'b0, miss);
        ptw_req_ready = 1'b1;
        @(posedge clk);
        #1 ptw_req_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        `CHK("midrst_req_ready", req_ready, 1);
        `CHK("midrst_resp_valid", resp_valid, 0);
        `CHK("midrst_hits", resp_hitsVec, 0);
        `CHK("midrst_miss", resp_miss, 0);
        `CHK("midrst_idx", resp_idx, 0);
        `CHK("midrst_valid_way", resp_valid_way, 0);
        `CHK("midrst_ptw_valid", ptw_req_valid, 0);
        `CHK("midrst_ptw_vpn", ptw_req_vpn, 0);
        `CHK("midrst_refill_valid", refill_valid, 0);
        `CHK("midrst_refill_way", refill_way, 0);
        `CHK("midrst_refill_idx", refill_idx, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        mrr = 0;
        @(negedge clk);
        ptw_resp_valid = 1'b1;
        #1;
        `CHK("stray_ptw_resp_ignored", refill_valid, 0);
        @(posedge clk);
        #1 ptw_resp_valid = 1'b0;
        lookup(31'h12345, 1'b0, miss);
        `CHK("post_rst_lookup_miss", miss, 1);
        serve(31'h12345, 0, 1'b1, 1'b0, 0);

        // Random lookups over a small tag/set pool so hits and evictions occur
        for (int i = 0; i < 60; i++) begin
            v = {27'($urandom_range(0, 5)), 4'($urandom_range(0, 3))};
            lookup(v, ($urandom_range(0, 7) == 0), miss);
            if (miss) serve(v, $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                            ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL sb_leftover %0d expected responses never seen", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
